layer_sequencer: RTL and testbench

//  Top-level controller for the two-layer CNN datapath. One start pulse sequences
//  NUM_LAYERS passes over the register file: read addresses, the multiplicator

---
 rtl/layer_sequencer.sv | 124 ++++++++++++
 tb/tb_layer_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Sequences NUM_LAYERS read/compute/write-back passes over the register file for the
// two-layer CNN datapath. Write addresses come from a binary counter behind a valid pipeline.
module layer_sequencer #(
  parameter int ADDRESS     = 4,
  parameter int DATANUM     = 15,
  parameter int MAC_LATENCY = 2,
  parameter int NUM_LAYERS  = 2,
  localparam int LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic [LAYER_W-1:0] layer,
  output logic               rd_en,
  output logic [ADDRESS-1:0] rd_addr,
  output logic               mac_clear,
  output logic               wr_en,
  output logic [ADDRESS-1:0] wr_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDRESS-1:0] LAST_ADDR  = ADDRESS'(DATANUM - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  logic [2:0]             state_q,   state_d;
  logic [LAYER_W-1:0]     layer_q,   layer_d;
  logic [ADDRESS-1:0]     rd_addr_q, rd_addr_d;
  logic [ADDRESS-1:0]     wr_addr_q, wr_addr_d;
  logic [MAC_LATENCY-1:0] vld_q,     vld_d;

  logic stall;
  logic rd_fire;
  logic wr_fire;

  // hold only matters while a pass is in flight; the pipeline is empty elsewhere.
  assign stall   = hold && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
  assign rd_fire = (state_q == S_ISSUE) && !hold;
  assign wr_fire = vld_q[MAC_LATENCY-1] && !stall;

  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    vld_d     = vld_q;

    if (!stall) begin
      vld_d[0] = rd_fire;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end

    // Counters saturate at the last address; the pass boundary resets them.
    if (rd_fire && (rd_addr_q != LAST_ADDR)) rd_addr_d = rd_addr_q + ADDRESS'(1);
    if (wr_fire && (wr_addr_q != LAST_ADDR)) wr_addr_d = wr_addr_q + ADDRESS'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ISSUE;
          layer_d   = '0;
          rd_addr_d = '0;
          wr_addr_d = '0;
        end
      end
      S_ISSUE: begin
        if (rd_fire && (rd_addr_q == LAST_ADDR)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_fire && (wr_addr_q == LAST_ADDR)) begin
          state_d = (layer_q == LAST_LAYER) ? S_DONE : S_NEXT;
        end
      end
      S_NEXT: begin
        state_d   = S_ISSUE;
        layer_d   = layer_q + LAYER_W'(1);
        rd_addr_d = '0;
        wr_addr_d = '0;
      end
      S_DONE: begin
        state_d   = S_IDLE;
        layer_d   = '0;
        rd_addr_d = '0;
        wr_addr_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      layer_q   <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      vld_q     <= vld_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mac_clear = (state_q == S_NEXT);
  assign layer     = layer_q;
  assign rd_en     = rd_fire;
  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_fire;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: two instances (default and 1-layer/latency-1) driven in lockstep
// and compared every cycle against a step-count model of a layer pass.
module tb_layer_sequencer;

  localparam int D = 15;
  localparam int P_L  [2] = '{2, 1};
  localparam int P_NL [2] = '{2, 1};

  logic clk = 1'b0;
  logic rst, start, hold;

  logic       busy_o    [2];
  logic       done_o    [2];
  logic [0:0] layer_o   [2];
  logic       rd_en_o   [2];
  logic [3:0] rd_addr_o [2];
  logic       mac_clr_o [2];
  logic       wr_en_o   [2];
  logic [3:0] wr_addr_o [2];

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 in a pass, 2 between layers, 3 done; step counts unstalled pass cycles.
  int m_ph    [2];
  int m_layer [2];
  int m_step  [2];

  int t_rel;
  int done_t  [2];
  int wr_cnt  [2];

  always #5 clk = ~clk;

  layer_sequencer #(.ADDRESS(4), .DATANUM(D), .MAC_LATENCY(2), .NUM_LAYERS(2)) dut0 (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .busy(busy_o[0]), .done(done_o[0]), .layer(layer_o[0]),
    .rd_en(rd_en_o[0]), .rd_addr(rd_addr_o[0]), .mac_clear(mac_clr_o[0]),
    .wr_en(wr_en_o[0]), .wr_addr(wr_addr_o[0])
  );

  layer_sequencer #(.ADDRESS(4), .DATANUM(D), .MAC_LATENCY(1), .NUM_LAYERS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .busy(busy_o[1]), .done(done_o[1]), .layer(layer_o[1]),
    .rd_en(rd_en_o[1]), .rd_addr(rd_addr_o[1]), .mac_clear(mac_clr_o[1]),
    .wr_en(wr_en_o[1]), .wr_addr(wr_addr_o[1])
  );

  task automatic check_val(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d expected=%0d", tag, t_rel, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ph[d] = 0; m_layer[d] = 0; m_step[d] = 0;
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model over the next edge.
  task automatic cyc(input bit s, input bit h, input bit r);
    @(posedge clk);
    #1;
    start = s; hold = h; rst = r;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int L, e_busy, e_done, e_layer, e_rd, e_ra, e_clr, e_wr, e_wa;
      L = P_L[d];
      e_busy = 0; e_done = 0; e_layer = 0; e_rd = 0; e_ra = 0; e_clr = 0; e_wr = 0; e_wa = 0;
      case (m_ph[d])
        1: begin
          e_busy  = 1;
          e_layer = m_layer[d];
          e_rd    = (!h && m_step[d] < D) ? 1 : 0;
          e_ra    = (m_step[d] < D) ? m_step[d] : D - 1;
          e_wr    = (!h && m_step[d] >= L && m_step[d] < D + L) ? 1 : 0;
          e_wa    = (m_step[d] >= L) ? m_step[d] - L : 0;
        end
        2: begin
          e_busy = 1; e_clr = 1; e_layer = m_layer[d]; e_ra = D - 1; e_wa = D - 1;
        end
        3: begin
          e_busy = 1; e_done = 1; e_layer = m_layer[d]; e_ra = D - 1; e_wa = D - 1;
        end
        default: ;
      endcase
      check_val($sformatf("d%0d.busy", d),      int'(busy_o[d]),    e_busy);
      check_val($sformatf("d%0d.done", d),      int'(done_o[d]),    e_done);
      check_val($sformatf("d%0d.layer", d),     int'(layer_o[d]),   e_layer);
      check_val($sformatf("d%0d.rd_en", d),     int'(rd_en_o[d]),   e_rd);
      check_val($sformatf("d%0d.rd_addr", d),   int'(rd_addr_o[d]), e_ra);
      check_val($sformatf("d%0d.mac_clear", d), int'(mac_clr_o[d]), e_clr);
      check_val($sformatf("d%0d.wr_en", d),     int'(wr_en_o[d]),   e_wr);
      check_val($sformatf("d%0d.wr_addr", d),   int'(wr_addr_o[d]), e_wa);
      if (done_o[d]) done_t[d] = t_rel;
      if (wr_en_o[d]) wr_cnt[d]++;

      if (r) begin
        m_ph[d] = 0; m_layer[d] = 0; m_step[d] = 0;
      end else begin
        case (m_ph[d])
          0: if (s) begin m_ph[d] = 1; m_layer[d] = 0; m_step[d] = 0; end
          1: if (!h) begin
            if (m_step[d] == D + L - 1) m_ph[d] = (m_layer[d] < P_NL[d] - 1) ? 2 : 3;
            else m_step[d]++;
          end
          2: begin m_ph[d] = 1; m_layer[d]++; m_step[d] = 0; end
          default: begin m_ph[d] = 0; m_layer[d] = 0; m_step[d] = 0; end
        endcase
      end
    end
    t_rel++;
  endtask

  task automatic clear_stats();
    t_rel = 0;
    for (int d = 0; d < 2; d++) begin
      done_t[d] = -1; wr_cnt[d] = 0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    model_reset();
    clear_stats();
    repeat (2) @(posedge clk);

    // Reset state, with hold/start toggling under reset.
    cyc(0, 0, 1);
    cyc(1, 1, 1);
    cyc(0, 0, 0);
    cyc(0, 1, 0);

    // Clean sequence, start at cycle 0.
    clear_stats();
    cyc(1, 0, 0);
    repeat (40) cyc(0, 0, 0);
    check_val("plain.done_cycle0", done_t[0], 36);
    check_val("plain.done_cycle1", done_t[1], 17);
    check_val("plain.writes0", wr_cnt[0], 2 * D);
    check_val("plain.writes1", wr_cnt[1], D);

    // hold over cycles 5..8 during the first pass.
    clear_stats();
    cyc(1, 0, 0);
    for (int c = 1; c <= 44; c++) cyc(0, (c >= 5 && c <= 8), 0);
    check_val("hold.done_cycle0", done_t[0], 40);
    check_val("hold.done_cycle1", done_t[1], 21);
    check_val("hold.writes0", wr_cnt[0], 2 * D);
    check_val("hold.writes1", wr_cnt[1], D);

    // start re-pulsed while busy and in DONE; a start at 38 begins again.
    clear_stats();
    cyc(1, 0, 0);
    for (int c = 1; c <= 80; c++) cyc((c == 10 || c == 36 || c == 38), 0, 0);
    check_val("restart.done_cycle0", done_t[0], 38 + 36);
    check_val("restart.writes0", wr_cnt[0], 4 * D);

    // hold across the last DRAIN cycle of layer 0.
    clear_stats();
    cyc(1, 0, 0);
    for (int c = 1; c <= 42; c++) cyc(0, (c == 17), 0);
    check_val("drainhold.done_cycle0", done_t[0], 37);
    check_val("drainhold.writes0", wr_cnt[0], 2 * D);

    // Reset mid-ISSUE at rd_addr=7, then a full clean sequence.
    clear_stats();
    cyc(1, 0, 0);
    for (int c = 1; c <= 12; c++) cyc(0, 0, (c == 8));
    clear_stats();
    cyc(1, 0, 0);
    repeat (40) cyc(0, 0, 0);
    check_val("postrst.done_cycle0", done_t[0], 36);
    check_val("postrst.writes0", wr_cnt[0], 2 * D);

    // Random start/hold/reset traffic.
    for (int c = 0; c < 2000; c++) begin
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
